flash_user_arbit: RTL and testbench

- Arbitrates flash access between up to USER_NUM user ports (config writer, instruction reader, register loader, etc.) using a req/ack/done handshake.
- Sits directly downstream of the user config stage and upstream of the flash command engine.
- Grants one owner at a time in round-robin order and muxes the owner's en/cmd/wr_data to the engine.
- Routes engine read bytes back to the owner only.

---
 rtl/flash_pkg.sv | 22 ++
 rtl/flash_rr_pick.sv | 20 ++
 rtl/flash_user_arbit.sv | 120 ++++++++++++
 tb/tb_flash_user_arbit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// flash_pkg: shared state encoding and command field layout for the flash arbiter
package flash_pkg;
  localparam int CMD_W        = 32;
  localparam int CMD_RW_BIT   = 31;
  localparam int CMD_LEN_MSB  = 23;
  localparam int CMD_LEN_LSB  = 16;
  localparam int CMD_ADDR_MSB = 15;
  localparam int CMD_ADDR_LSB = 0;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b11
  } arb_state_t;
  function automatic logic [CMD_W-1:0] mk_cmd(input logic rw, input logic [7:0] len, input logic [15:0] addr);
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_RW_BIT] = rw;
    c[CMD_LEN_MSB:CMD_LEN_LSB] = len;
    c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    return c;
  endfunction
endpackage

// File: rtl/flash_rr_pick.sv
// flash_rr_pick: combinational first-set-bit search starting at ptr, wrapping modulo N
// Ports: req (request vector), ptr (search start), win (winner index), found (any req set)
module flash_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         found
);
  always_comb begin
    win = ptr;
    found = |req;
    // scan from the farthest offset down so the nearest set bit is written last
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) win = W'((int'(ptr) + i) % N);
    end
  end
endmodule

// File: rtl/flash_user_arbit.sv
// flash_user_arbit: round-robin req/ack/done arbiter muxing user ports onto one flash command engine
// Ports: clk_sys/rst; user_req/ack/done/en/cmd/wr_data/rd_data/rd_data_valid (user side);
// flash_en/cmd/wr_data/rd_data/rd_data_valid/busy (engine side); arb_owner/arb_busy/arb_timeout (status).
// Optional macro FLASH_ARBIT_TIMEOUT_EN: BUSY watchdog forcing release after TIMEOUT_CYC cycles.
module flash_user_arbit
  import flash_pkg::*;
#(
  parameter int          USER_NUM    = 4,
  parameter int          UID_W       = 2,
  parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF,
  parameter int          U_DLY       = 1
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic [USER_NUM-1:0]       user_req,
  output logic [USER_NUM-1:0]       user_ack,
  input  logic [USER_NUM-1:0]       user_done,
  input  logic [USER_NUM-1:0]       user_en,
  input  logic [USER_NUM*CMD_W-1:0] user_cmd,
  input  logic [USER_NUM*8-1:0]     user_wr_data,
  output logic [7:0]                user_rd_data,
  output logic [USER_NUM-1:0]       user_rd_data_valid,
  output logic                      flash_en,
  output logic [CMD_W-1:0]          flash_cmd,
  output logic [7:0]                flash_wr_data,
  input  logic [7:0]                flash_rd_data,
  input  logic                      flash_rd_data_valid,
  input  logic                      flash_busy,
  output logic [UID_W-1:0]          arb_owner,
  output logic                      arb_busy,
  output logic                      arb_timeout
);
  if (UID_W != $clog2(USER_NUM) || USER_NUM < 2 || USER_NUM > 8 || TIMEOUT_CYC == 20'd0 || U_DLY < 0) begin : g_bad_cfg
    $error("flash_user_arbit: inconsistent parameters");
  end
  arb_state_t          state;
  logic [UID_W-1:0]    rr_ptr;
  logic [UID_W-1:0]    win;
  logic                found;
  logic [USER_NUM-1:0] owner_oh;
  logic                owner_done;
  logic                expire;
  logic [UID_W-1:0]    ptr_next;
  flash_rr_pick #(.N(USER_NUM), .W(UID_W)) u_pick (
    .req  (user_req),
    .ptr  (rr_ptr),
    .win  (win),
    .found(found)
  );
  assign owner_oh   = USER_NUM'(1) << arb_owner;
  assign owner_done = user_done[arb_owner];
  assign ptr_next   = (arb_owner == UID_W'(USER_NUM - 1)) ? '0 : arb_owner + UID_W'(1);
`ifdef FLASH_ARBIT_TIMEOUT_EN
  logic [19:0] cnt;
  // cnt is held at 0 outside BUSY, so it starts from 0 on every grant
  assign expire = (state == BUSY) && !owner_done && (cnt == TIMEOUT_CYC - 20'd1);
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt <= '0;
      arb_timeout <= 1'b0;
    end else begin
      cnt <= (state == BUSY) ? cnt + 20'd1 : '0;
      arb_timeout <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign arb_timeout = 1'b0;
`endif
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      arb_owner <= '0;
      user_ack <= '0;
      user_rd_data <= '0;
      user_rd_data_valid <= '0;
      flash_en <= 1'b0;
      flash_cmd <= '0;
      flash_wr_data <= '0;
      arb_busy <= 1'b0;
    end else begin
      user_ack <= '0;
      flash_en <= 1'b0;
      user_rd_data_valid <= '0;
      // engine read bytes only reach a user while someone owns the engine
      if (state != IDLE && flash_rd_data_valid) begin
        user_rd_data <= flash_rd_data;
        user_rd_data_valid <= owner_oh;
      end
      case (state)
        IDLE: begin
          if (found) begin
            arb_owner <= win;
            user_ack <= USER_NUM'(1) << win;
            state <= BUSY;
            arb_busy <= 1'b1;
          end
        end
        BUSY: begin
          flash_cmd <= user_cmd[int'(arb_owner)*CMD_W +: CMD_W];
          flash_wr_data <= user_wr_data[int'(arb_owner)*8 +: 8];
          flash_en <= user_en[arb_owner] && !owner_done && !expire;
          if (owner_done || expire) state <= DRAIN;
        end
        DRAIN: begin
          if (!flash_busy) begin
            state <= IDLE;
            arb_busy <= 1'b0;
            rr_ptr <= ptr_next;
          end
        end
        default: begin
          state <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_user_arbit.sv
// tb_flash_user_arbit: directed self-checking bench for flash_user_arbit
module tb_flash_user_arbit;
  import flash_pkg::*;
`ifdef FLASH_ARBIT_TIMEOUT_EN
  localparam logic [19:0] TCYC = 20'd16;
`else
  localparam logic [19:0] TCYC = 20'hFFFFF;
`endif
  logic        clk_sys = 1'b0;
  logic        rst;
  logic [3:0]  user_req, user_ack, user_done, user_en, user_rd_data_valid;
  logic [127:0] user_cmd;
  logic [31:0] user_wr_data;
  logic [7:0]  user_rd_data, flash_wr_data, flash_rd_data;
  logic        flash_en, flash_rd_data_valid, flash_busy, arb_busy, arb_timeout;
  logic [31:0] flash_cmd;
  logic [1:0]  arb_owner;
  int total = 0;
  int bad = 0;
  int seq [5] = '{0, 1, 2, 3, 0};
  flash_user_arbit #(.USER_NUM(4), .UID_W(2), .TIMEOUT_CYC(TCYC), .U_DLY(1)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .user_req(user_req), .user_ack(user_ack), .user_done(user_done), .user_en(user_en),
    .user_cmd(user_cmd), .user_wr_data(user_wr_data),
    .user_rd_data(user_rd_data), .user_rd_data_valid(user_rd_data_valid),
    .flash_en(flash_en), .flash_cmd(flash_cmd), .flash_wr_data(flash_wr_data),
    .flash_rd_data(flash_rd_data), .flash_rd_data_valid(flash_rd_data_valid), .flash_busy(flash_busy),
    .arb_owner(arb_owner), .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic release_owner(input int u);
    user_done = 4'b0001 << u;
    tick;
    user_done = '0;
    chk("drain_busy", 32'(arb_busy), 1);
    tick;
    chk("back_idle", 32'(arb_busy), 0);
  endtask
  initial begin
    rst = 1'b1;
    user_req = '0; user_done = '0; user_en = '0; user_cmd = '0; user_wr_data = '0;
    flash_rd_data = '0; flash_rd_data_valid = 1'b0; flash_busy = 1'b0;
    tick;
    tick;
    chk("rst_ack", 32'(user_ack), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_owner", 32'(arb_owner), 0);
    chk("rst_cmd", flash_cmd, 0);
    chk("rst_en", 32'(flash_en), 0);
    chk("rst_to", 32'(arb_timeout), 0);
    rst = 1'b0;
    tick;
    user_req = 4'b0010;
    user_en[1] = 1'b1;
    user_cmd[32 +: 32] = mk_cmd(1'b0, 8'h06, 16'h8000);
    user_wr_data[8 +: 8] = 8'hA5;
    user_en[0] = 1'b1;
    user_cmd[0 +: 32] = 32'hDEAD_BEEF;
    tick;
    chk("single_ack", 32'(user_ack), 32'h2);
    chk("single_owner", 32'(arb_owner), 1);
    chk("single_busy", 32'(arb_busy), 1);
    tick;
    user_req = '0;
    chk("single_reack", 32'(user_ack), 0);
    chk("single_en", 32'(flash_en), 1);
    chk("single_cmd", flash_cmd, 32'h0006_8000);
    chk("single_data", 32'(flash_wr_data), 32'hA5);
    user_done = 4'b0010;
    tick;
    user_done = '0;
    chk("single_en_off", 32'(flash_en), 0);
    chk("single_drain", 32'(arb_busy), 1);
    tick;
    chk("single_idle", 32'(arb_busy), 0);
    user_en = '0;
    user_req = 4'b1010;
    tick;
    chk("ptr2_ack", 32'(user_ack), 32'h8);
    chk("ptr2_owner", 32'(arb_owner), 3);
    user_req = '0;
    release_owner(3);
    user_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick;
      chk("rr_ack", 32'(user_ack), 32'(4'b0001 << seq[g]));
      chk("rr_owner", 32'(arb_owner), 32'(seq[g]));
      for (int k = 0; k < 4; k++) begin
        tick;
        chk("rr_noack", 32'(user_ack), 0);
      end
      release_owner(seq[g]);
    end
    user_req = 4'b0100;
    user_cmd[64 +: 32] = mk_cmd(1'b1, 8'h04, 16'h0010);
    tick;
    chk("rd_ack", 32'(user_ack), 32'h4);
    user_req = '0;
    flash_rd_data = 8'h11;
    flash_rd_data_valid = 1'b1;
    tick;
    chk("rd_v1", 32'(user_rd_data_valid), 32'h4);
    chk("rd_d1", 32'(user_rd_data), 32'h11);
    flash_rd_data = 8'h22;
    tick;
    chk("rd_v2", 32'(user_rd_data_valid), 32'h4);
    chk("rd_d2", 32'(user_rd_data), 32'h22);
    flash_rd_data_valid = 1'b0;
    tick;
    chk("rd_v0", 32'(user_rd_data_valid), 0);
    chk("rd_cmd", flash_cmd, 32'h8004_0010);
    release_owner(2);
    flash_rd_data = 8'h33;
    flash_rd_data_valid = 1'b1;
    tick;
    chk("rd_idle", 32'(user_rd_data_valid), 0);
    flash_rd_data_valid = 1'b0;
    user_req = 4'b0001;
    tick;
    chk("dr_ack", 32'(user_ack), 32'h1);
    user_req = 4'b1000;
    flash_busy = 1'b1;
    user_done = 4'b0001;
    tick;
    user_done = '0;
    for (int k = 0; k < 10; k++) begin
      chk("dr_hold", 32'(arb_busy), 1);
      chk("dr_noack", 32'(user_ack), 0);
      tick;
    end
    flash_busy = 1'b0;
    tick;
    chk("dr_idle", 32'(arb_busy), 0);
    chk("dr_idle_ack", 32'(user_ack), 0);
    tick;
    chk("dr_next_ack", 32'(user_ack), 32'h8);
    chk("dr_next_owner", 32'(arb_owner), 3);
    user_req = '0;
    release_owner(3);
    user_req = 4'b0010;
    tick;
    chk("sp_ack", 32'(user_ack), 32'h2);
    user_done = 4'b1000;
    tick;
    chk("sp_noack", 32'(user_ack), 0);
    chk("sp_busy", 32'(arb_busy), 1);
    chk("sp_owner", 32'(arb_owner), 1);
    user_req = '0;
    user_done = '0;
    tick;
    chk("sp_still", 32'(arb_busy), 1);
    release_owner(1);
    user_done = 4'b0100;
    tick;
    user_done = '0;
    chk("idle_done", 32'(arb_busy), 0);
    chk("idle_done_ack", 32'(user_ack), 0);
`ifdef FLASH_ARBIT_TIMEOUT_EN
    user_req = 4'b0001;
    tick;
    chk("to_ack", 32'(user_ack), 32'h1);
    user_req = '0;
    repeat (15) tick;
    chk("to_early", 32'(arb_timeout), 0);
    tick;
    chk("to_pulse", 32'(arb_timeout), 1);
    chk("to_drain", 32'(arb_busy), 1);
    tick;
    chk("to_pulse_end", 32'(arb_timeout), 0);
    chk("to_idle", 32'(arb_busy), 0);
    user_done = 4'b0001;
    tick;
    user_done = '0;
    chk("to_late_done", 32'(arb_busy), 0);
    user_req = 4'b0010;
    tick;
    chk("to_next_ack", 32'(user_ack), 32'h2);
    user_req = '0;
    release_owner(1);
`else
    chk("to_tied", 32'(arb_timeout), 0);
`endif
    user_req = 4'b0100;
    user_en[2] = 1'b1;
    tick;
    chk("rb_ack", 32'(user_ack), 32'h4);
    user_req = '0;
    tick;
    chk("rb_en", 32'(flash_en), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    user_en = '0;
    chk("rb_en0", 32'(flash_en), 0);
    chk("rb_busy0", 32'(arb_busy), 0);
    chk("rb_owner0", 32'(arb_owner), 0);
    chk("rb_cmd0", flash_cmd, 0);
    chk("rb_rd0", 32'(user_rd_data), 0);
    user_req = 4'b0010;
    tick;
    chk("rb_regrant", 32'(user_ack), 32'h2);
    user_req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
